roi_descramble_mover: RTL and testbench



---
 rtl/roi_descramble_mover_if.sv | 30 +++
 rtl/roi_descramble_mover.sv | 121 ++++++++++++
 tb/tb_roi_descramble_mover.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/roi_descramble_mover_if.sv
// rtl/roi_descramble_mover_if.sv - handshake, descrambler and memory bus bundle for the ROI mover
interface roi_descramble_mover_if;
   logic        start;
   logic [15:0] key;
   logic        busy;
   logic        done;
   logic [11:0] ds_in_addr;
   logic [15:0] ds_key;
   logic        ds_rst_n;
   logic [11:0] ds_out_addr;
   logic [11:0] face_raddr;
   logic [7:0]  face_rdata;
   logic        frm_we;
   logic [15:0] frm_waddr;
   logic [7:0]  frm_wdata;

   // mover side: drives the descrambler, face buffer and frame memory
   modport master (
      input  start, key, ds_out_addr, face_rdata,
      output busy, done, ds_in_addr, ds_key, ds_rst_n,
             face_raddr, frm_we, frm_waddr, frm_wdata
   );

   // environment side: requests, descrambler and memories
   modport slave (
      output start, key, ds_out_addr, face_rdata,
      input  busy, done, ds_in_addr, ds_key, ds_rst_n,
             face_raddr, frm_we, frm_waddr, frm_wdata
   );
endinterface

// File: rtl/roi_descramble_mover.sv
// rtl/roi_descramble_mover.sv - restores a 64x64 scrambled face region into the 256x256 frame
module roi_descramble_mover #(
   parameter int ROW0   = 97,
   parameter int COL0   = 86,
   parameter int DS_LAT = 12
) (
   input  logic clk,
   input  logic reset,
   roi_descramble_mover_if.master bus
);

   localparam int             CW       = (DS_LAT > 1) ? $clog2(DS_LAT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DS_LAT - 1);
   localparam logic [7:0]     ROW0_B   = 8'(ROW0);
   localparam logic [7:0]     COL0_B   = 8'(COL0);

   typedef enum logic [2:0] {
      S_IDLE, S_KICK, S_WAIT, S_READ, S_WRITE, S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [11:0]    idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [15:0]    key_q, key_d;
   logic [11:0]    in_addr_q, in_addr_d;
   logic [11:0]    raddr_q, raddr_d;
   logic [15:0]    waddr_q, waddr_d;
   logic [7:0]     wdata_q, wdata_d;
   logic [7:0]     row_sum, col_sum;

   // ROI coordinates never carry past 255 for legal parameters, so row/col concatenate into the address
   assign row_sum = ROW0_B + {2'b00, idx_q[11:6]};
   assign col_sum = COL0_B + {2'b00, idx_q[5:0]};

   // state and datapath registers; reset abandons any walk in progress
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         key_q     <= '0;
         in_addr_q <= '0;
         raddr_q   <= '0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         key_q     <= key_d;
         in_addr_q <= in_addr_d;
         raddr_q   <= raddr_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   // next-state sequencing: kick the descrambler, wait out its latency, read, write
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      key_d     = key_q;
      in_addr_d = in_addr_q;
      raddr_d   = raddr_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               key_d     = bus.key;
               idx_d     = '0;
               in_addr_d = '0;
               state_d   = S_KICK;
            end
         end
         S_KICK: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               raddr_d = bus.ds_out_addr;
               state_d = S_READ;
            end
         end
         S_READ: begin
            waddr_d = {row_sum, col_sum};
            state_d = S_WRITE;
         end
         S_WRITE: begin
            wdata_d = bus.face_rdata;
            if (idx_q == 12'hFFF) begin
               state_d = S_DONE;
            end else begin
               idx_d     = idx_q + 12'd1;
               in_addr_d = idx_q + 12'd1;
               state_d   = S_KICK;
            end
         end
         S_DONE: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // face data is only valid during WRITE, so write data passes straight through then and holds afterwards
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.ds_rst_n   = (state_q != S_KICK);
   assign bus.ds_in_addr = in_addr_q;
   assign bus.ds_key     = key_q;
   assign bus.face_raddr = raddr_q;
   assign bus.frm_we     = (state_q == S_WRITE);
   assign bus.frm_waddr  = waddr_q;
   assign bus.frm_wdata  = (state_q == S_WRITE) ? bus.face_rdata : wdata_q;

endmodule

// File: tb/tb_roi_descramble_mover.sv
// tb/tb_roi_descramble_mover.sv - self-checking bench for roi_descramble_mover
module tb_roi_descramble_mover;
   localparam int DS_LAT = 12;

   typedef struct { int addr; int data; } wr_t;
   typedef struct { bit rev; int idx; int addr; int data; } vec_t;

   logic clk = 0;
   logic reset = 0;
   roi_descramble_mover_if bus();

   roi_descramble_mover #(.ROW0(97), .COL0(86), .DS_LAT(DS_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   bit        rev = 0;
   int        dcnt = 0;
   logic [7:0] frd_q = 8'h00;

   // descrambler model: output only meaningful once the latency after restart release has elapsed
   always @(posedge clk) begin
      if (!bus.ds_rst_n) dcnt <= 0;
      else if (dcnt < 255) dcnt <= dcnt + 1;
      frd_q <= bus.face_raddr[7:0];
   end
   assign bus.ds_out_addr = (dcnt >= DS_LAT - 1) ?
                            (rev ? 12'd4095 - bus.ds_in_addr : bus.ds_in_addr) : 12'hA5A;
   assign bus.face_rdata  = frd_q;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   wr_t  sb_q[$];
   int   cap_addr[2][4096];
   int   cap_data[2][4096];
   int   wr_cnt, kick_cnt, first_we, second_we, last_we;
   logic [11:0] kick_addr;
   logic prev_rst_n = 1'b1;
   bit   key_chk = 0;
   vec_t vecs[8];

   function automatic void check_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void push_run(input bit r);
      for (int i = 0; i < 4096; i++) begin
         wr_t e;
         e.addr = (97 + i / 64) * 256 + 86 + i % 64;
         e.data = r ? ((4095 - i) % 256) : (i % 256);
         sb_q.push_back(e);
      end
   endfunction

   function automatic void clear_run();
      wr_cnt = 0; kick_cnt = 0; first_we = -1; second_we = -1; last_we = -1;
      kick_addr = '0;
   endfunction

   // advance one cycle and monitor the sampled outputs
   task automatic step();
      @(negedge clk);
      cyc++;
      if (bus.frm_we) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_write", bus.frm_waddr, -1);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            check_eq("wr_addr", bus.frm_waddr, e.addr);
            check_eq("wr_data", bus.frm_wdata, e.data);
         end
         if (wr_cnt < 4096) begin
            cap_addr[rev][wr_cnt] = bus.frm_waddr;
            cap_data[rev][wr_cnt] = bus.frm_wdata;
         end
         if (wr_cnt == 0) first_we = cyc;
         if (wr_cnt == 1) second_we = cyc;
         last_we = cyc;
         wr_cnt++;
      end
      if (!bus.ds_rst_n) begin
         check_eq("rst_n_single_cycle", prev_rst_n, 1);
         check_eq("kick_order", bus.ds_in_addr, kick_cnt % 4096);
         kick_addr = bus.ds_in_addr;
         kick_cnt++;
      end else if (bus.busy && kick_cnt > 0) begin
         check_eq("in_addr_hold", bus.ds_in_addr, kick_addr);
      end
      if (key_chk && bus.busy) check_eq("ds_key_stable", bus.ds_key, 16'hB530);
      prev_rst_n = bus.ds_rst_n;
   endtask

   initial begin
      int c0, done_cyc, n_pulse;
      bit got;
      vecs[0] = '{0, 0,    24918, 8'h00};
      vecs[1] = '{0, 1,    24919, 8'h01};
      vecs[2] = '{0, 63,   24981, 8'h3F};
      vecs[3] = '{0, 64,   25174, 8'h40};
      vecs[4] = '{0, 4095, 41109, 8'hFF};
      vecs[5] = '{1, 0,    24918, 8'hFF};
      vecs[6] = '{1, 64,   25174, 8'hBF};
      vecs[7] = '{1, 199,  25693, 8'h38};

      bus.start = 0;
      bus.key = 16'h0000;
      clear_run();

      // reset state
      reset = 0;
      step(); step();
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_done", bus.done, 0);
      check_eq("rst_ds_rst_n", bus.ds_rst_n, 1);
      check_eq("rst_in_addr", bus.ds_in_addr, 0);
      check_eq("rst_ds_key", bus.ds_key, 0);
      check_eq("rst_face_raddr", bus.face_raddr, 0);
      check_eq("rst_frm_we", bus.frm_we, 0);
      check_eq("rst_frm_waddr", bus.frm_waddr, 0);
      check_eq("rst_frm_wdata", bus.frm_wdata, 0);
      reset = 1;
      step();

      // reverse-map run aborted by reset during WAIT of idx 200
      rev = 1;
      clear_run();
      push_run(1);
      bus.start = 1; bus.key = 16'h1234;
      step();
      bus.start = 0;
      got = 0;
      for (int i = 0; i < 5000 && !got; i++) begin
         if (!bus.ds_rst_n && bus.ds_in_addr == 12'd200) got = 1;
         else step();
      end
      check_eq("reach_idx200", got, 1);
      step();
      reset = 0;
      step();
      check_eq("abort_busy", bus.busy, 0);
      check_eq("abort_frm_we", bus.frm_we, 0);
      check_eq("abort_ds_rst_n", bus.ds_rst_n, 1);
      reset = 1;
      for (int i = 0; i < 40; i++) step();
      check_eq("abort_write_count", wr_cnt, 200);
      check_eq("abort_busy_stays_low", bus.busy, 0);
      sb_q.delete();

      // identity run with ignored starts and key toggles while busy
      rev = 0;
      clear_run();
      push_run(0);
      bus.start = 1; bus.key = 16'hB530;
      step();
      c0 = cyc;
      bus.start = 0;
      key_chk = 1;
      n_pulse = 0;
      if (!bus.ds_rst_n && bus.ds_in_addr == 12'd0) begin bus.start = 1; n_pulse++; end
      got = 0;
      done_cyc = -1;
      for (int i = 0; i < 70000 && !got; i++) begin
         step();
         bus.start = 0;
         if (i % 500 == 0) bus.key = ~bus.key;
         if (bus.done) begin
            got = 1;
            done_cyc = cyc;
            check_eq("busy_at_done", bus.busy, 1);
         end else if (!bus.ds_rst_n && (bus.ds_in_addr == 12'd100 || bus.ds_in_addr == 12'd4095)) begin
            bus.start = 1;
            n_pulse++;
         end
      end
      check_eq("done_seen", got, 1);
      bus.start = 1;
      step();
      bus.start = 0;
      check_eq("done_one_cycle", bus.done, 0);
      check_eq("busy_falls_after_done", bus.busy, 0);
      step();
      check_eq("no_restart_busy", bus.busy, 0);
      check_eq("no_restart_rst_n", bus.ds_rst_n, 1);
      key_chk = 0;
      check_eq("start_pulses_applied", n_pulse, 3);
      check_eq("first_write_cycle", first_we - c0, 14);
      check_eq("second_write_cycle", second_we - c0, 29);
      check_eq("done_cycle", done_cyc - c0, 61440);
      check_eq("last_write_before_done", done_cyc - last_we, 1);
      check_eq("write_count", wr_cnt, 4096);
      check_eq("kick_count", kick_cnt, 4096);
      check_eq("scoreboard_drained", sb_q.size(), 0);

      // table-driven spot checks of captured writes
      for (int v = 0; v < 8; v++) begin
         check_eq($sformatf("vec%0d_addr", v), cap_addr[vecs[v].rev][vecs[v].idx], vecs[v].addr);
         check_eq($sformatf("vec%0d_data", v), cap_data[vecs[v].rev][vecs[v].idx], vecs[v].data);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
